// File: rtl/sw_threshold_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sw_threshold_monitor: sync + debounce N switches, popcount vs K, LED/pulse |
// | Optional macro STICKY_ALARM_EN adds the sticky ALARM flag.    Rev 1.0      |
// +----------------------------------------------------------------------------+
module sw_threshold_monitor #(
  parameter int N         = 4,
  parameter int K         = 1,
  parameter int MODE      = 0,
  parameter int DB_CYCLES = 4
) (
  input  logic                     CLOCK_50,
  input  logic                     RST,
  input  logic [N-1:0]             SW,
  input  logic                     CLR,
  output logic                     LEDR,
  output logic [$clog2(N+1)-1:0]   COUNT,
  output logic                     CHANGE,
  output logic                     ALARM
);
  localparam int            CW  = $clog2(N+1);
  localparam logic [CW-1:0] K_C = CW'(K);

  if (K > N || K < 0) begin : g_k_check
    $error("sw_threshold_monitor: K must lie in 0..N");
  end

  logic [N-1:0] sw_s1_q, sw_s1_d;
  logic [N-1:0] sw_s2_q, sw_s2_d;
  logic [N-1:0] db;

  always_comb begin
    sw_s1_d = SW;
    sw_s2_d = sw_s1_q;
  end

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      sw_s1_q <= sw_s1_d;
      sw_s2_q <= sw_s2_d;
    end
  end

  if (DB_CYCLES == 0) begin : g_db_bypass
    assign db = sw_s2_q;
  end else begin : g_db
    localparam int             DBW     = $clog2(DB_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

    for (genvar i = 0; i < N; i++) begin : g_bit
      logic [DBW-1:0] cnt_q, cnt_d;
      logic           db_q, db_d;

      // Counter restarts whenever the input agrees with the debounced value,
      // so only an uninterrupted run of DB_CYCLES disagreeing samples commits.
      always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        if (sw_s2_q[i] == db_q) begin
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          db_d  = sw_s2_q[i];
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + DBW'(1);
        end
      end

      always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
          cnt_q <= '0;
          db_q  <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          db_q  <= db_d;
        end
      end

      assign db[i] = db_q;
    end
  end

  logic [CW-1:0] pop;
  logic          match;

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + CW'(db[i]);
    end
    match = (pop <= K_C);
    case (MODE)
      1:       match = (pop >= K_C);
      2:       match = (pop == K_C);
      default: match = (pop <= K_C);
    endcase
  end

  logic [CW-1:0] count_q, count_d;
  logic          led_q, led_d;
  logic          change_q, change_d;
  logic          primed_q, primed_d;

  // COUNT and LEDR come from the same db sample, so they never disagree.
  always_comb begin
    count_d  = pop;
    led_d    = match;
    change_d = primed_q && (match != led_q);
    primed_d = 1'b1;
  end

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      count_q  <= '0;
      led_q    <= 1'b0;
      change_q <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      led_q    <= led_d;
      change_q <= change_d;
      primed_q <= primed_d;
    end
  end

  assign COUNT  = count_q;
  assign LEDR   = led_q;
  assign CHANGE = change_q;

`ifdef STICKY_ALARM_EN
  logic alarm_q, alarm_d;

  // A violation on the same edge as CLR keeps the alarm set.
  always_comb begin
    alarm_d = alarm_q;
    if (primed_q && !led_d) begin
      alarm_d = 1'b1;
    end else if (CLR) begin
      alarm_d = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign ALARM = alarm_q;
`else
  logic unused_clr;
  assign unused_clr = CLR;
  assign ALARM      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sw_threshold_monitor.sv
`timescale 1ns/1ps
// Bench: instance A (K=1, MODE=0, DB=4) and instance B (K=2, MODE=2, DB=0) checked against a window model.
module tb_sw_threshold_monitor;
  localparam int N  = 4;
  localparam int CW = $clog2(N + 1);
`ifdef STICKY_ALARM_EN
  localparam int ALARM_ON = 1;
`else
  localparam int ALARM_ON = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic [N-1:0]  sw;
  logic          led_a, chg_a, alm_a, led_b, chg_b, alm_b;
  logic [CW-1:0] cnt_a, cnt_b;

  int n_chk  = 0;
  int n_fail = 0;
  logic cmp_en = 1'b0;

  always #10 clk = ~clk;

  sw_threshold_monitor #(.N(N), .K(1), .MODE(0), .DB_CYCLES(4)) dut_a (
    .CLOCK_50(clk), .RST(rst), .SW(sw), .CLR(clr),
    .LEDR(led_a), .COUNT(cnt_a), .CHANGE(chg_a), .ALARM(alm_a));

  sw_threshold_monitor #(.N(N), .K(2), .MODE(2), .DB_CYCLES(0)) dut_b (
    .CLOCK_50(clk), .RST(rst), .SW(sw), .CLR(clr),
    .LEDR(led_b), .COUNT(cnt_b), .CHANGE(chg_b), .ALARM(alm_b));

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int db_of(input int j);
    return (j == 0) ? 4 : 0;
  endfunction
  function automatic int k_of(input int j);
    return (j == 0) ? 1 : 2;
  endfunction
  function automatic int mode_of(input int j);
    return (j == 0) ? 0 : 2;
  endfunction
  function automatic int popc(input logic [N-1:0] v);
    int c = 0;
    for (int b = 0; b < N; b++) c += int'(v[b]);
    return c;
  endfunction
  function automatic logic cmp_rule(input int c, input int k, input int m);
    case (m)
      1:       return c >= k;
      2:       return c == k;
      default: return c <= k;
    endcase
  endfunction

  // Model: hist[j][k] is SW as sampled k edges ago. A debounced bit flips once
  // the DB_CYCLES synchronised samples (2..DB+1 edges old) all disagree with it.
  logic [N-1:0] hist [2][8];
  logic [N-1:0] mdb [2];
  int           mcount [2];
  logic         mled [2], mchg [2], malm [2], mprimed [2];
  logic [N-1:0] h_t [8];
  logic [N-1:0] ndb_t;
  int           pc_t;
  logic         nled_t, all_t;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < 2; j++) begin
        for (int k = 0; k < 8; k++) hist[j][k] <= '0;
        mdb[j] <= '0; mcount[j] <= 0; mled[j] <= 1'b0;
        mchg[j] <= 1'b0; malm[j] <= 1'b0; mprimed[j] <= 1'b0;
      end
    end else begin
      for (int j = 0; j < 2; j++) begin
        for (int k = 7; k > 0; k--) h_t[k] = hist[j][k-1];
        h_t[0] = sw;
        pc_t   = (db_of(j) == 0) ? popc(h_t[2]) : popc(mdb[j]);
        ndb_t  = mdb[j];
        if (db_of(j) > 0) begin
          for (int b = 0; b < N; b++) begin
            all_t = 1'b1;
            for (int k = 2; k < db_of(j) + 2; k++)
              if (h_t[k][b] == mdb[j][b]) all_t = 1'b0;
            if (all_t) ndb_t[b] = ~mdb[j][b];
          end
        end
        nled_t = cmp_rule(pc_t, k_of(j), mode_of(j));
        for (int k = 0; k < 8; k++) hist[j][k] <= h_t[k];
        mdb[j]     <= ndb_t;
        mcount[j]  <= pc_t;
        mchg[j]    <= mprimed[j] && (nled_t != mled[j]);
        mled[j]    <= nled_t;
        mprimed[j] <= 1'b1;
        if (ALARM_ON != 0) begin
          if (mprimed[j] && !nled_t) malm[j] <= 1'b1;
          else if (clr)              malm[j] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_count_a",  int'(cnt_a), mcount[0]);
      chk("m_led_a",    int'(led_a), int'(mled[0]));
      chk("m_change_a", int'(chg_a), int'(mchg[0]));
      chk("m_alarm_a",  int'(alm_a), int'(malm[0]));
      chk("m_count_b",  int'(cnt_b), mcount[1]);
      chk("m_led_b",    int'(led_b), int'(mled[1]));
      chk("m_change_b", int'(chg_b), int'(mchg[1]));
      chk("m_alarm_b",  int'(alm_b), int'(malm[1]));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; sw = '0; clr = 1'b0;
    tick(3);
    cmp_en = 1'b1;
    chk("t1_rst_count", int'(cnt_a), 0);
    chk("t1_rst_led",   int'(led_a), 0);
    chk("t1_rst_chg",   int'(chg_a), 0);
    chk("t1_rst_alarm", int'(alm_a), 0);
    rst = 1'b0;
    tick(1);
    chk("t1_first_led", int'(led_a), 1);
    chk("t1_first_chg", int'(chg_a), 0);
    tick(4);

    sw = 4'b0001;
    tick(6); chk("t2_cnt_early", int'(cnt_a), 0);
    tick(1); chk("t2_cnt_1", int'(cnt_a), 1);
    chk("t2_led_1", int'(led_a), 1);
    chk("t2_chg_none", int'(chg_a), 0);
    tick(3);

    sw = 4'b0011;
    tick(2); chk("t4_b_cnt_early", int'(cnt_b), 1);
    tick(1); chk("t4_b_led_0011", int'(led_b), 1);
    chk("t4_b_cnt_0011", int'(cnt_b), 2);
    tick(3); chk("t2_cnt_hold", int'(cnt_a), 1);
    tick(1); chk("t2_cnt_2", int'(cnt_a), 2);
    chk("t2_led_0", int'(led_a), 0);
    chk("t2_chg_pulse", int'(chg_a), 1);
    tick(1); chk("t2_chg_end", int'(chg_a), 0);

    for (int i = 0; i < 10; i++) begin
      sw[2] = ~sw[2];
      tick(2);
      chk("t3_bounce_cnt", int'(cnt_a), 2);
    end
    sw[2] = 1'b1;
    tick(3); chk("t4_b_led_0111", int'(led_b), 0);
    chk("t4_b_cnt_0111", int'(cnt_b), 3);
    tick(3); chk("t3_cnt_hold", int'(cnt_a), 2);
    tick(1); chk("t3_cnt_3", int'(cnt_a), 3);

    chk("t5_alarm_viol", int'(alm_a), ALARM_ON);
    sw = 4'b0001;
    tick(8); chk("t5_led_back", int'(led_a), 1);
    chk("t5_alarm_sticky", int'(alm_a), ALARM_ON);
    clr = 1'b1; tick(1); clr = 1'b0;
    chk("t5_alarm_clr", int'(alm_a), 0);
    clr = 1'b1; sw = 4'b0011;
    tick(8); chk("t5_alarm_set_wins", int'(alm_a), ALARM_ON);
    clr = 1'b0;

    sw = 4'b0000;
    tick(8); chk("t6_cnt_zero", int'(cnt_a), 0);
    sw = 4'b0001;
    tick(4);
    rst = 1'b1;
    #1;
    chk("t6_rst_count", int'(cnt_a), 0);
    chk("t6_rst_led",   int'(led_a), 0);
    chk("t6_rst_chg",   int'(chg_a), 0);
    chk("t6_rst_alarm", int'(alm_a), 0);
    tick(1);
    rst = 1'b0;
    tick(6); chk("t6_cnt_early", int'(cnt_a), 0);
    tick(1); chk("t6_cnt_1", int'(cnt_a), 1);
    chk("t6_led", int'(led_a), 1);
    chk("t6_chg", int'(chg_a), 0);
    tick(2);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
